// File: rtl/power_state_controller.sv
// Power-state sequencer: steps a sensor between ACTIVE, IDLE, SLEEP and WAKING
// from activity, wake and security inputs, gating the sensor supply and clock.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ACTIVE | sensor fully on; counting quiet cycles toward IDLE
// IDLE   | sensor still on; counting quiet cycles toward SLEEP
// SLEEP  | sensor supply and clock off; counting toward a periodic poll
// WAKING | supply on, clock still gated while the sensor settles
module power_state_controller #(
   parameter logic [15:0] IDLE_CYCLES   = 16'd1000,
   parameter logic [15:0] SLEEP_CYCLES  = 16'd10000,
   parameter logic [15:0] POLL_CYCLES   = 16'd50000,
   parameter logic [15:0] SETTLE_CYCLES = 16'd8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       activity,
   input  logic       ext_wake,
   input  logic       security_violation,
   output logic [1:0] power_state,
   output logic       wakeup_event,
   output logic       sensor_power_en,
   output logic       sensor_clk_en
);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'b00,
      ST_IDLE   = 2'b01,
      ST_SLEEP  = 2'b10,
      ST_WAKING = 2'b11
   } state_t;

   // Terminal counts; a parameter of 0 behaves like 1 so the counter never wraps.
   localparam logic [15:0] IDLE_TC   = (IDLE_CYCLES   < 16'd2) ? 16'd0 : IDLE_CYCLES   - 16'd1;
   localparam logic [15:0] SLEEP_TC  = (SLEEP_CYCLES  < 16'd2) ? 16'd0 : SLEEP_CYCLES  - 16'd1;
   localparam logic [15:0] POLL_TC   = (POLL_CYCLES   < 16'd2) ? 16'd0 : POLL_CYCLES   - 16'd1;
   localparam logic [15:0] SETTLE_TC = (SETTLE_CYCLES < 16'd2) ? 16'd0 : SETTLE_CYCLES - 16'd1;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        wake_q, wake_d;
   logic        pwr_en_q, pwr_en_d;
   logic        clk_en_q, clk_en_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      wake_d  = 1'b0;
      if (!enable) begin
         state_d = ST_ACTIVE;
         cnt_d   = 16'd0;
      end else begin
         unique case (state_q)
            ST_ACTIVE: begin
               if (activity) begin
                  cnt_d = 16'd0;
               end else if (cnt_q == IDLE_TC) begin
                  state_d = ST_IDLE;
                  cnt_d   = 16'd0;
               end
            end
            ST_IDLE: begin
               if (security_violation || activity) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = 16'd0;
               end else if (cnt_q == SLEEP_TC) begin
                  state_d = ST_SLEEP;
                  cnt_d   = 16'd0;
               end
            end
            ST_SLEEP: begin
               // All wake causes merge into one transition and one pulse.
               if (security_violation || ext_wake || (cnt_q == POLL_TC)) begin
                  state_d = ST_WAKING;
                  cnt_d   = 16'd0;
                  wake_d  = 1'b1;
               end
            end
            ST_WAKING: begin
               if (cnt_q == SETTLE_TC) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = 16'd0;
               end
            end
            default: begin
               state_d = ST_ACTIVE;
               cnt_d   = 16'd0;
            end
         endcase
      end
      pwr_en_d = (state_d != ST_SLEEP);
      clk_en_d = (state_d == ST_ACTIVE) || (state_d == ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_ACTIVE;
         cnt_q    <= 16'd0;
         wake_q   <= 1'b0;
         pwr_en_q <= 1'b1;
         clk_en_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wake_q   <= wake_d;
         pwr_en_q <= pwr_en_d;
         clk_en_q <= clk_en_d;
      end
   end

   assign power_state     = state_q;
   assign wakeup_event    = wake_q;
   assign sensor_power_en = pwr_en_q;
   assign sensor_clk_en   = clk_en_q;

endmodule

// File: doc/power_state_controller.md
POWER_STATE_CONTROLLER -- requirements
Module: power_state_controller

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 16'd1000, meaning consecutive no-activity cycles in ACTIVE before entering IDLE.
REQ-002 The block SHALL have parameter SLEEP_CYCLES, default 16'd10000, meaning consecutive no-activity cycles in IDLE before entering SLEEP.
REQ-003 The block SHALL have parameter POLL_CYCLES, default 16'd50000, meaning cycles in SLEEP before a periodic poll wake.
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 16'd8, meaning sensor power-up settle cycles in WAKING.
REQ-005 The block SHALL have these ports: clock  in  1  system clock (rising edge); one clock domain only.
REQ-006 The block SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have: enable  in  1  power management enable; 0 forces ACTIVE.
REQ-008 The block SHALL have: activity  in  1  sensor activity / detection strobe, level-sampled each cycle.
REQ-009 The block SHALL have: ext_wake  in  1  external wake request, level-sampled.
REQ-010 The block SHALL have: security_violation  in  1  tamper/security event, level-sampled.
REQ-011 The block SHALL have: power_state  out  2  00 ACTIVE, 01 IDLE, 10 SLEEP, 11 WAKING; feeds the communication interface status read.
REQ-012 The block SHALL have: wakeup_event  out  1  one-cycle pulse on every SLEEP->WAKING transition; feeds interrupt logic.
REQ-013 The block SHALL have: sensor_power_en  out  1  sensor analog supply enable.
REQ-014 The block SHALL have: sensor_clk_en  out  1  sensor clock gate enable.

Function
REQ-015 All outputs SHALL be registered; power_state SHALL equal the current FSM state encoding.
REQ-016 A single 16-bit counter SHALL count cycles; it SHALL clear to 0 on every state transition and never wrap (every terminal value causes a transition).
REQ-017 ACTIVE: activity=1 clears counter; else counter increments; when counter==IDLE_CYCLES-1 and activity=0 -> IDLE.
REQ-018 IDLE: activity=1 or security_violation=1 -> ACTIVE (no wakeup_event); else when counter==SLEEP_CYCLES-1 -> SLEEP.
REQ-019 SLEEP: ext_wake=1, security_violation=1, or counter==POLL_CYCLES-1 -> WAKING, with wakeup_event=1 in the first WAKING cycle only; activity SHALL be ignored in SLEEP.
REQ-020 WAKING: when counter==SETTLE_CYCLES-1 -> ACTIVE; inputs other than enable SHALL be ignored.
REQ-021 Output decode: ACTIVE/IDLE -> power_en=1, clk_en=1; SLEEP -> power_en=0, clk_en=0; WAKING -> power_en=1, clk_en=0.
REQ-022 Priority per cycle: enable=0 > security_violation > ext_wake > activity > timer expiry.
REQ-023 enable=0 SHALL force ACTIVE next cycle from any state, hold counter at 0, and generate no wakeup_event.
REQ-024 Transition latency SHALL be exactly one clock from the qualifying input/count to the new power_state.
REQ-025 Parameters of 0 or 1 SHALL be treated as 1 (transition after one qualifying cycle).

Reset
REQ-026 reset_n=0 SHALL immediately force ACTIVE, counter=0, wakeup_event=0, sensor_power_en=1, sensor_clk_en=1, independent of clock.
REQ-027 Reset asserted mid-WAKING or mid-SLEEP SHALL abort the sequence without a wakeup_event pulse; operation resumes from ACTIVE on the first clock after deassertion.

Verification (IDLE_CYCLES=4, SLEEP_CYCLES=8, POLL_CYCLES=16, SETTLE_CYCLES=3)
REQ-028 Idle descent: enable=1, all inputs 0 from reset -> power_state 01 after 4 cycles, 10 after 8 further cycles, clk_en/power_en 0 in SLEEP.
REQ-029 Poll wake: remain in SLEEP, no inputs -> after 16 cycles power_state 11, wakeup_event high exactly 1 cycle, power_en=1 clk_en=0, ACTIVE 3 cycles later.
REQ-030 Activity restart: activity pulse at ACTIVE count 3 -> no IDLE entry, IDLE reached 4 cycles after pulse; activity in IDLE -> ACTIVE next cycle, no wakeup_event.
REQ-031 Simultaneous: in SLEEP, ext_wake and security_violation same cycle as poll expiry -> single WAKING entry, single wakeup_event pulse.
REQ-032 Disable: enable=0 during SLEEP -> ACTIVE next cycle, wakeup_event stays 0, counter held 0 until enable=1.
REQ-033 Async reset: assert reset_n=0 between clock edges during WAKING -> outputs at reset values immediately, no wakeup_event after release.
